branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Execute-stage block of the RV32I pipeline. Consumes register operands, the decoded control-transfer class and the PC.
- Evaluates the branch condition using one signed comparator and one unsigned comparator. Computes the target and link address.
- Registers the decision and drives the fetch redirect.
- A small FSM squashes wrong-path instructions for a fixed number of cycles after each taken transfer.

Parameters:
- nb_bits, 32, datapath and address width.
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a taken transfer (legal range 1..7).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction present in execute
- stall_i  in  1  pipeline stall; freezes all state
- is_branch_i  in  1  conditional branch (B-type)
- is_jal_i  in  1  JAL
- is_jalr_i  in  1  JALR
- funct3_i  in  3  branch condition select
- rs1_i  in  nb_bits  operand 1
- rs2_i  in  nb_bits  operand 2
- pc_i  in  nb_bits  instruction PC
- imm_i  in  nb_bits  sign-extended immediate
- redirect_o  out  1  one-cycle pulse: fetch must load target_o
- target_o  out  nb_bits  redirect address
- link_o  out  nb_bits  pc+4 of the last accepted jump
- taken_o  out  1  registered decision of the last accepted instruction
- flush_o  out  1  squash younger stages
- misalign_o  out  1  one-cycle pulse: taken target has bit1 set
- illegal_o  out  1  one-cycle pulse: branch with funct3 010/011

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, FSM=RUN, flush counter=0. Reset mid-flush aborts the flush immediately.
- Accept condition: valid_i & ~stall_i & ~flush_o. When flush_o=1, valid_i is a wrong-path instruction. It is ignored, and no output pulses are generated for it.
- Condition table (is_branch_i):
  - 000 BEQ: equal
  - 001 BNE: ~equal
  - 100 BLT: signed lesser
  - 101 BGE: ~signed lesser
  - 110 BLTU: unsigned lesser
  - 111 BGEU: ~unsigned lesser
  - 010/011: not taken, and illegal_o pulses on the next cycle.
- JAL/JALR: always taken. Priority if several class bits are set: jalr > jal > branch.
- Target computation:
  - Branch/JAL target = pc_i+imm_i, modulo 2^nb_bits (wrap, no carry out).
  - JALR target = (rs1_i+imm_i) with bit0 forced to 0.
  - link = pc_i+4, wrapping.
- Misalignment: a taken transfer whose target has bit1=1 pulses misalign_o. It gives no redirect_o and no flush.
- Latency: accepted at edge N → taken_o, target_o, link_o update at edge N, visible in cycle N+1. redirect_o and misalign_o are one-cycle pulses in cycle N+1.
- taken_o, target_o and link_o hold until the next accepted instruction.
- link_o updates only for JAL/JALR.
- FSM:
  - RUN → FLUSH on an accepted taken, aligned transfer. Counter loads FLUSH_CYCLES-1 and flush_o=1 from cycle N+1.
  - FLUSH: counter decrements each non-stalled cycle. At counter=0 with ~stall_i → RUN, and flush_o drops in the following cycle.
  - flush_o is therefore high for exactly FLUSH_CYCLES unstalled cycles.
- Stall: stall_i=1 freezes the FSM, counter and all registers.
  - Pulse outputs (redirect_o, misalign_o, illegal_o) are cleared after one cycle even during stall; a pulse is never repeated.
- Non-control instructions (valid_i with no class bit set) are accepted and set taken_o=0. They produce no pulses.

Test Plan:
- BLT with rs1=0xFFFFFFFF (-1), rs2=1, pc=0x100, imm=0x20 → cycle+1: taken_o=1, redirect_o=1, target_o=0x120, flush_o high exactly 2 cycles.
- BLTU with rs1=0xFFFFFFFF, rs2=1 → taken_o=0, no redirect, flush_o=0. BGEU with the same operands → taken, target=pc+imm.
- JALR with rs1=0x1001, imm=0x4, pc=0x200 → target_o=0x1004 (bit0 cleared), link_o=0x204. A second JALR with rs1=0x1002, imm=0 → misalign_o pulse, no redirect, no flush.
- Taken BEQ (rs1=rs2=5), followed by BNE-taken instructions in the next two cycles → both squashed (no second redirect). An instruction in the third cycle is accepted normally.
- Taken branch, then stall_i=1 for 3 cycles during FLUSH → flush_o stays high through the stall and ends after 2 unstalled cycles. redirect_o pulses only once.
- rst_n_i asserted asynchronously in the first flush cycle → all outputs 0 immediately. After release, the next valid branch with funct3=010 → illegal_o pulse, taken_o=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: compares operands, computes target and link, and registers the redirect decision.
// Latency: 1 cycle from acceptance to outputs; stall_i freezes all state, and the squash FSM blocks acceptance while flush_o is high.
module branch_resolve_unit #(
    parameter int nb_bits      = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               is_branch_i,
    input  logic               is_jal_i,
    input  logic               is_jalr_i,
    input  logic [2:0]         funct3_i,
    input  logic [nb_bits-1:0] rs1_i,
    input  logic [nb_bits-1:0] rs2_i,
    input  logic [nb_bits-1:0] pc_i,
    input  logic [nb_bits-1:0] imm_i,
    output logic               redirect_o,
    output logic [nb_bits-1:0] target_o,
    output logic [nb_bits-1:0] link_o,
    output logic               taken_o,
    output logic               flush_o,
    output logic               misalign_o,
    output logic               illegal_o
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               taken_q, redirect_q, misalign_q, illegal_q;
    logic [nb_bits-1:0] target_q, link_q;

    logic               accept, is_jump, equal, lt_s, lt_u, cond, illegal_d, taken_d;
    logic               redirect_d, misalign_d;
    logic [nb_bits-1:0] pc_sum, rs1_sum, target_d, link_d;

    assign accept  = valid_i & ~stall_i & (state_q == S_RUN);
    assign is_jump = is_jal_i | is_jalr_i;
    assign equal   = (rs1_i == rs2_i);
    assign lt_s    = $signed(rs1_i) < $signed(rs2_i);
    assign lt_u    = rs1_i < rs2_i;
    assign pc_sum  = pc_i + imm_i;
    assign rs1_sum = rs1_i + imm_i;
    assign link_d  = pc_i + nb_bits'(4);

    always_comb begin
        cond      = 1'b0;
        illegal_d = 1'b0;
        case (funct3_i)
            3'b000:  cond = equal;
            3'b001:  cond = ~equal;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: illegal_d = 1'b1;
        endcase
    end

    // Jumps override the branch class, so a jump never reports an illegal condition.
    assign taken_d    = is_jump | (is_branch_i & cond);
    assign target_d   = is_jalr_i ? {rs1_sum[nb_bits-1:1], 1'b0} : pc_sum;
    assign redirect_d = accept & taken_d & ~target_d[1];
    assign misalign_d = accept & taken_d & target_d[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            link_q     <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // Pulses are recomputed every cycle so they clear even while stalled.
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            illegal_q  <= accept & is_branch_i & ~is_jump & illegal_d;
            if (accept) begin
                taken_q  <= taken_d;
                target_q <= target_d;
                if (is_jump) link_q <= link_d;
            end
            case (state_q)
                S_RUN: begin
                    if (redirect_d) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_FLUSH: begin
                    if (!stall_i) begin
                        if (cnt_q == 3'd0) state_q <= S_RUN;
                        else               cnt_q   <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign redirect_o = redirect_q;
    assign target_o   = target_q;
    assign link_o     = link_q;
    assign taken_o    = taken_q;
    assign flush_o    = (state_q == S_FLUSH);
    assign misalign_o = misalign_q;
    assign illegal_o  = illegal_q;

endmodule
